// File: rtl/syscall_unit.sv
// Syscall service unit: console print char/int, exit/exit2, with an output byte FIFO.
// Define SYSCALL_HEX_EN to add funct 34 (print hex as "0x" + 8 lowercase nibbles).
module syscall_unit #(
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        syscall_valid,
    input  logic [31:0] syscall_funct,
    input  logic [31:0] syscall_param1,
    output logic        syscall_busy,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        halted,
    output logic [7:0]  exit_code,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SIGN,
        S_DIGIT,
        S_EMIT,
        S_HEX
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        mag_q, mag_d;
    logic [3:0]         pow_q, pow_d;
    logic [3:0]         digit_q, digit_d;
    logic               started_q, started_d;
    logic               halted_q, halted_d;
    logic [7:0]         exit_q, exit_d;
    logic [FIFO_AW:0]   wptr_q, wptr_d;
    logic [FIFO_AW:0]   rptr_q, rptr_d;
    logic [7:0]         mem_q [FIFO_DEPTH];
`ifdef SYSCALL_HEX_EN
    logic [3:0]         hex_q, hex_d;
    logic [3:0]         nib;
`endif

    logic        full, empty, accept, push_req, push_en, pop, emit;
    logic [7:0]  push_data;
    logic [31:0] pow_val;

    function automatic logic [31:0] pow10(input logic [3:0] idx);
        case (idx)
            4'd0:    pow10 = 32'd1;
            4'd1:    pow10 = 32'd10;
            4'd2:    pow10 = 32'd100;
            4'd3:    pow10 = 32'd1000;
            4'd4:    pow10 = 32'd10000;
            4'd5:    pow10 = 32'd100000;
            4'd6:    pow10 = 32'd1000000;
            4'd7:    pow10 = 32'd10000000;
            4'd8:    pow10 = 32'd100000000;
            4'd9:    pow10 = 32'd1000000000;
            default: pow10 = 32'd1;
        endcase
    endfunction

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                   (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);

    assign syscall_busy = (state_q != S_IDLE) | full;
    assign accept       = syscall_valid & ~syscall_busy & ~halted_q;
    assign out_valid    = ~empty;
    assign out_data     = empty ? 8'h00 : mem_q[rptr_q[FIFO_AW-1:0]];
    assign pop          = out_valid & out_ready;
    assign push_en      = push_req & ~full;
    assign halted       = halted_q;
    assign exit_code    = exit_q;
    assign done         = halted_q & empty & (state_q == S_IDLE);
    assign pow_val      = pow10(pow_q);
    assign emit         = (digit_q != 4'd0) | started_q | (pow_q == 4'd0);
`ifdef SYSCALL_HEX_EN
    assign nib          = mag_q[31:28];
`endif

    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        pow_d     = pow_q;
        digit_d   = digit_q;
        started_d = started_q;
        halted_d  = halted_q;
        exit_d    = exit_q;
        push_req  = 1'b0;
        push_data = 8'h00;
`ifdef SYSCALL_HEX_EN
        hex_d     = hex_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (syscall_funct)
                        32'd11: begin
                            push_req  = 1'b1;
                            push_data = syscall_param1[7:0];
                        end
                        32'd1: begin
                            mag_d     = syscall_param1[31] ?
                                        (~syscall_param1 + 32'd1) :
                                        syscall_param1;
                            pow_d     = 4'd9;
                            digit_d   = 4'd0;
                            started_d = 1'b0;
                            state_d   = syscall_param1[31] ? S_SIGN : S_DIGIT;
                        end
                        32'd10: begin
                            halted_d = 1'b1;
                            exit_d   = 8'h00;
                        end
                        32'd17: begin
                            halted_d = 1'b1;
                            exit_d   = syscall_param1[7:0];
                        end
`ifdef SYSCALL_HEX_EN
                        32'd34: begin
                            mag_d   = syscall_param1;
                            hex_d   = 4'd0;
                            state_d = S_HEX;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            S_SIGN: begin
                if (!full) begin
                    push_req  = 1'b1;
                    push_data = 8'h2D;
                    state_d   = S_DIGIT;
                end
            end
            S_DIGIT: begin
                if (mag_q >= pow_val) begin
                    mag_d   = mag_q - pow_val;
                    digit_d = digit_q + 4'd1;
                end else begin
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (!(emit && full)) begin
                    if (emit) begin
                        push_req  = 1'b1;
                        push_data = 8'h30 + {4'h0, digit_q};
                        started_d = 1'b1;
                    end
                    if (pow_q == 4'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        pow_d   = pow_q - 4'd1;
                        digit_d = 4'd0;
                        state_d = S_DIGIT;
                    end
                end
            end
`ifdef SYSCALL_HEX_EN
            S_HEX: begin
                if (!full) begin
                    push_req = 1'b1;
                    if (hex_q == 4'd0) begin
                        push_data = 8'h30;
                    end else if (hex_q == 4'd1) begin
                        push_data = 8'h78;
                    end else begin
                        push_data = (nib < 4'd10) ? 8'h30 + {4'h0, nib} :
                                                    8'h57 + {4'h0, nib};
                        mag_d = {mag_q[27:0], 4'h0};
                    end
                    if (hex_q == 4'd9) state_d = S_IDLE;
                    else               hex_d = hex_q + 4'd1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign wptr_d = wptr_q + (FIFO_AW+1)'(push_en);
    assign rptr_d = rptr_q + (FIFO_AW+1)'(pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            mag_q     <= 32'd0;
            pow_q     <= 4'd0;
            digit_q   <= 4'd0;
            started_q <= 1'b0;
            halted_q  <= 1'b0;
            exit_q    <= 8'h00;
            wptr_q    <= '0;
            rptr_q    <= '0;
`ifdef SYSCALL_HEX_EN
            hex_q     <= 4'd0;
`endif
        end else begin
            state_q   <= state_d;
            mag_q     <= mag_d;
            pow_q     <= pow_d;
            digit_q   <= digit_d;
            started_q <= started_d;
            halted_q  <= halted_d;
            exit_q    <= exit_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
`ifdef SYSCALL_HEX_EN
            hex_q     <= hex_d;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (push_en) mem_q[wptr_q[FIFO_AW-1:0]] <= push_data;
    end

endmodule
